// File: rtl/qcs_fir_src_drv.sv
// I/Q stimulus source for the FIR input stream: buffers pushed samples in a
// small FIFO and replays them as packets of programmable length, with a
// programmable idle gap between samples. Reports done, underrun and level.
module qcs_fir_src_drv #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned GAPW  = 8,
  parameter int unsigned LENW  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_vld,
  input  logic [DW-1:0]            in_i,
  input  logic [DW-1:0]            in_q,
  output logic                     in_rdy,
  input  logic                     start,
  input  logic                     stop,
  input  logic [LENW-1:0]          pkt_len,
  input  logic [GAPW-1:0]          cfg_gap,
  output logic                     data_vld,
  output logic [DW-1:0]            data_i,
  output logic [DW-1:0]            data_q,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned SW = 2 * DW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // FIFO storage and bookkeeping
  logic [SW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   count_q;
  logic [LW-1:0]   count_d;
  logic            in_rdy_q;
  logic            push_c;
  logic            pop_c;
  logic [SW-1:0]   rd_data_c;

  // Packet sequencer state
  state_e          state_q;
  logic [LENW-1:0] rem_q;
  logic [GAPW-1:0] gcnt_q;
  logic [GAPW-1:0] gcnt_ld_q;
  logic            data_vld_q;
  logic [DW-1:0]   out_i_q;
  logic [DW-1:0]   out_q_q;
  logic            busy_q;
  logic            done_q;
  logic            underrun_q;

  // Handshake, pop decision and next occupancy; pop only sees samples already
  // registered in the FIFO, so there is no push-to-pop bypass.
  always_comb begin
    push_c    = in_vld && in_rdy_q;
    pop_c     = (state_q == ST_RUN) && !stop && (count_q != '0);
    rd_data_c = mem[rd_ptr_q];
    count_d   = count_q + LW'(push_c) - LW'(pop_c);
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= {in_i, in_q};
    end
  end

  // FIFO pointers (wrap naturally at power-of-two depth), level and ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      in_rdy_q <= 1'b1;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q  <= count_d;
      in_rdy_q <= (count_d != LW'(DEPTH));
    end
  end

  // Packet FSM with registered stream outputs; stop overrides everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      gcnt_q     <= '0;
      gcnt_ld_q  <= '0;
      data_vld_q <= 1'b0;
      out_i_q    <= '0;
      out_q_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      data_vld_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!stop && start && (pkt_len != '0)) begin
            rem_q      <= pkt_len;
            gcnt_ld_q  <= cfg_gap;
            underrun_q <= 1'b0;
            state_q    <= ST_RUN;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (pop_c) begin
            data_vld_q <= 1'b1;
            out_i_q    <= rd_data_c[SW-1:DW];
            out_q_q    <= rd_data_c[DW-1:0];
            rem_q      <= rem_q - LENW'(1);
            if (rem_q == LENW'(1)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (gcnt_ld_q != '0) begin
              state_q <= ST_GAP;
              gcnt_q  <= gcnt_ld_q;
            end
          end else begin
            underrun_q <= 1'b1;
          end
        end
        ST_GAP: begin
          if (stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gcnt_q <= gcnt_q - GAPW'(1);
            if (gcnt_q == GAPW'(1)) begin
              state_q <= ST_RUN;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_rdy   = in_rdy_q;
  assign level    = count_q;
  assign data_vld = data_vld_q;
  assign data_i   = out_i_q;
  assign data_q   = out_q_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_qcs_fir_src_drv.sv
// Directed bench for qcs_fir_src_drv: packets, gaps, underrun, full FIFO with
// pointer wrap, stop abort and asynchronous reset.
module tb_qcs_fir_src_drv;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned GAPW  = 8;
  localparam int unsigned LENW  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_vld;
  logic [DW-1:0]     in_i;
  logic [DW-1:0]     in_q;
  logic              in_rdy;
  logic              start;
  logic              stop;
  logic [LENW-1:0]   pkt_len;
  logic [GAPW-1:0]   cfg_gap;
  logic              data_vld;
  logic [DW-1:0]     data_i;
  logic [DW-1:0]     data_q;
  logic              busy;
  logic              done;
  logic              underrun;
  logic [4:0]        level;

  int chk_n    = 0;
  int chk_ok   = 0;
  int vld_cnt  = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  qcs_fir_src_drv #(.DW(DW), .DEPTH(DEPTH), .GAPW(GAPW), .LENW(LENW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_vld   (in_vld),
    .in_i     (in_i),
    .in_q     (in_q),
    .in_rdy   (in_rdy),
    .start    (start),
    .stop     (stop),
    .pkt_len  (pkt_len),
    .cfg_gap  (cfg_gap),
    .data_vld (data_vld),
    .data_i   (data_i),
    .data_q   (data_q),
    .busy     (busy),
    .done     (done),
    .underrun (underrun),
    .level    (level)
  );

  // One clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    vld_cnt  += int'(data_vld);
    done_cnt += int'(done);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    in_vld  = 1'b0;
    in_i    = '0;
    in_q    = '0;
    start   = 1'b0;
    stop    = 1'b0;
    pkt_len = '0;
    cfg_gap = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    vld_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic push_n(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      in_vld = 1'b1;
      in_i   = DW'(base + k);
      in_q   = DW'(-(base + k));
      tick();
    end
    in_vld = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    chk_n++; if (level !== 5'd0)     $display("FAIL reset_level got %0d exp 0", level);      else chk_ok++;
    chk_n++; if (in_rdy !== 1'b1)    $display("FAIL reset_in_rdy got %b exp 1", in_rdy);     else chk_ok++;
    chk_n++; if (data_vld !== 1'b0)  $display("FAIL reset_vld got %b exp 0", data_vld);      else chk_ok++;
    chk_n++; if (data_i !== 16'd0)   $display("FAIL reset_data_i got %0d exp 0", data_i);    else chk_ok++;
    chk_n++; if (data_q !== 16'd0)   $display("FAIL reset_data_q got %0d exp 0", data_q);    else chk_ok++;
    chk_n++; if (busy !== 1'b0)      $display("FAIL reset_busy got %b exp 0", busy);         else chk_ok++;
    chk_n++; if (done !== 1'b0)      $display("FAIL reset_done got %b exp 0", done);         else chk_ok++;
    chk_n++; if (underrun !== 1'b0)  $display("FAIL reset_underrun got %b exp 0", underrun); else chk_ok++;
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    apply_reset();
    push_n(1, 4);
    chk_n++; if (level !== 5'd4) $display("FAIL b2b_level_pre got %0d exp 4", level); else chk_ok++;
    pkt_len = 16'd4;
    cfg_gap = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk_n++; if (busy !== 1'b1)     $display("FAIL b2b_busy_start got %b exp 1", busy);    else chk_ok++;
    chk_n++; if (data_vld !== 1'b0) $display("FAIL b2b_vld_start got %b exp 0", data_vld); else chk_ok++;
    for (int c = 0; c < 4; c++) begin
      tick();
      exp_done = (c == 3);
      chk_n++; if (data_vld !== 1'b1)          $display("FAIL b2b_vld[%0d] got %b exp 1", c, data_vld);                        else chk_ok++;
      chk_n++; if (data_i !== DW'(c + 1))      $display("FAIL b2b_data_i[%0d] got %0d exp %0d", c, data_i, c + 1);             else chk_ok++;
      chk_n++; if (data_q !== DW'(-(c + 1)))   $display("FAIL b2b_data_q[%0d] got %0h exp %0h", c, data_q, DW'(-(c + 1)));     else chk_ok++;
      chk_n++; if (done !== exp_done)          $display("FAIL b2b_done[%0d] got %b exp %b", c, done, exp_done);                else chk_ok++;
    end
    chk_n++; if (busy !== 1'b0)     $display("FAIL b2b_busy_end got %b exp 0", busy);         else chk_ok++;
    chk_n++; if (level !== 5'd0)    $display("FAIL b2b_level_end got %0d exp 0", level);      else chk_ok++;
    chk_n++; if (underrun !== 1'b0) $display("FAIL b2b_underrun got %b exp 0", underrun);     else chk_ok++;
    tick();
    chk_n++; if (data_vld !== 1'b0) $display("FAIL b2b_vld_after got %b exp 0", data_vld);    else chk_ok++;
    chk_n++; if (data_i !== 16'd4)  $display("FAIL b2b_hold_i got %0d exp 4", data_i);        else chk_ok++;
    chk_n++; if (done !== 1'b0)     $display("FAIL b2b_done_after got %b exp 0", done);       else chk_ok++;
  endtask

  task automatic test_gap();
    int   pat [7] = '{1, 0, 0, 1, 0, 0, 1};
    int   s = 0;
    logic exp_v;
    logic exp_done;
    apply_reset();
    push_n(10, 6);
    pkt_len = 16'd3;
    cfg_gap = 8'd2;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 7; p++) begin
      tick();
      exp_v    = (pat[p] != 0);
      exp_done = (p == 6);
      chk_n++; if (data_vld !== exp_v) $display("FAIL gap_vld[%0d] got %b exp %b", p, data_vld, exp_v); else chk_ok++;
      chk_n++; if (done !== exp_done)  $display("FAIL gap_done[%0d] got %b exp %b", p, done, exp_done); else chk_ok++;
      if (exp_v) begin
        chk_n++; if (data_i !== DW'(10 + s)) $display("FAIL gap_data_i[%0d] got %0d exp %0d", s, data_i, 10 + s); else chk_ok++;
        s++;
      end
    end
    chk_n++; if (level !== 5'd3)  $display("FAIL gap_level got %0d exp 3", level);     else chk_ok++;
    chk_n++; if (busy !== 1'b0)   $display("FAIL gap_busy got %b exp 0", busy);        else chk_ok++;
    chk_n++; if (done_cnt !== 1)  $display("FAIL gap_done_cnt got %0d exp 1", done_cnt); else chk_ok++;
  endtask

  task automatic test_underrun();
    apply_reset();
    push_n(20, 2);
    pkt_len = 16'd5;
    cfg_gap = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_n++; if (data_i !== 16'd20 || data_vld !== 1'b1) $display("FAIL ur_s0 got vld=%b i=%0d exp vld=1 i=20", data_vld, data_i); else chk_ok++;
    tick();
    chk_n++; if (data_i !== 16'd21 || data_vld !== 1'b1) $display("FAIL ur_s1 got vld=%b i=%0d exp vld=1 i=21", data_vld, data_i); else chk_ok++;
    tick();
    chk_n++; if (data_vld !== 1'b0) $display("FAIL ur_vld_empty got %b exp 0", data_vld); else chk_ok++;
    chk_n++; if (underrun !== 1'b1) $display("FAIL ur_flag got %b exp 1", underrun);     else chk_ok++;
    repeat (7) tick();
    chk_n++; if (vld_cnt !== 2)     $display("FAIL ur_vld_cnt_wait got %0d exp 2", vld_cnt); else chk_ok++;
    chk_n++; if (busy !== 1'b1)     $display("FAIL ur_busy_wait got %b exp 1", busy);     else chk_ok++;
    in_vld = 1'b1; in_i = 16'd22; in_q = 16'd0;
    tick();
    chk_n++; if (data_vld !== 1'b0) $display("FAIL ur_no_bypass got %b exp 0", data_vld); else chk_ok++;
    in_i = 16'd23;
    tick();
    chk_n++; if (data_i !== 16'd22 || data_vld !== 1'b1) $display("FAIL ur_s2 got vld=%b i=%0d exp vld=1 i=22", data_vld, data_i); else chk_ok++;
    in_i = 16'd24;
    tick();
    chk_n++; if (data_i !== 16'd23 || data_vld !== 1'b1) $display("FAIL ur_s3 got vld=%b i=%0d exp vld=1 i=23", data_vld, data_i); else chk_ok++;
    in_vld = 1'b0;
    tick();
    chk_n++; if (data_i !== 16'd24 || data_vld !== 1'b1) $display("FAIL ur_s4 got vld=%b i=%0d exp vld=1 i=24", data_vld, data_i); else chk_ok++;
    chk_n++; if (done !== 1'b1)     $display("FAIL ur_done got %b exp 1", done);          else chk_ok++;
    tick();
    chk_n++; if (busy !== 1'b0)     $display("FAIL ur_busy_end got %b exp 0", busy);      else chk_ok++;
    chk_n++; if (underrun !== 1'b1) $display("FAIL ur_sticky got %b exp 1", underrun);    else chk_ok++;
    chk_n++; if (done_cnt !== 1)    $display("FAIL ur_done_cnt got %0d exp 1", done_cnt); else chk_ok++;
  endtask

  task automatic test_full_wrap();
    logic exp_rdy;
    logic exp_done;
    apply_reset();
    for (int k = 0; k < DEPTH + 2; k++) begin
      in_vld = 1'b1;
      in_i   = DW'(100 + k);
      in_q   = DW'(k);
      tick();
      exp_rdy = (k < 15);
      chk_n++; if (in_rdy !== exp_rdy) $display("FAIL full_rdy[%0d] got %b exp %b", k, in_rdy, exp_rdy); else chk_ok++;
    end
    chk_n++; if (level !== 5'd16) $display("FAIL full_level got %0d exp 16", level); else chk_ok++;
    in_i    = 16'd200;
    pkt_len = 16'd16;
    cfg_gap = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_done = (k == 16);
      chk_n++; if (data_vld !== 1'b1 || data_i !== DW'(99 + k)) $display("FAIL full_out[%0d] got vld=%b i=%0d exp vld=1 i=%0d", k, data_vld, data_i, 99 + k); else chk_ok++;
      chk_n++; if (done !== exp_done) $display("FAIL full_done[%0d] got %b exp %b", k, done, exp_done); else chk_ok++;
      in_i = DW'(200 + k);
    end
    in_vld = 1'b0;
    chk_n++; if (level !== 5'd15) $display("FAIL full_level_mid got %0d exp 15", level); else chk_ok++;
    pkt_len = 16'd15;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk_n++; if (data_vld !== 1'b1 || data_i !== DW'(201 + k)) $display("FAIL wrap_out[%0d] got vld=%b i=%0d exp vld=1 i=%0d", k, data_vld, data_i, 201 + k); else chk_ok++;
    end
    chk_n++; if (level !== 5'd0) $display("FAIL wrap_level got %0d exp 0", level); else chk_ok++;
    chk_n++; if (done !== 1'b1)  $display("FAIL wrap_done got %b exp 1", done);    else chk_ok++;
  endtask

  task automatic test_stop();
    logic exp_v;
    apply_reset();
    push_n(50, 10);
    pkt_len = 16'd8;
    cfg_gap = 8'd1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 5; p++) begin
      tick();
      exp_v = ((p % 2) == 0);
      chk_n++; if (data_vld !== exp_v) $display("FAIL stop_vld[%0d] got %b exp %b", p, data_vld, exp_v); else chk_ok++;
      if (exp_v) begin
        chk_n++; if (data_i !== DW'(50 + p / 2)) $display("FAIL stop_data[%0d] got %0d exp %0d", p, data_i, 50 + p / 2); else chk_ok++;
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_n++; if (data_vld !== 1'b0) $display("FAIL stop_vld_after got %b exp 0", data_vld); else chk_ok++;
    chk_n++; if (busy !== 1'b0)     $display("FAIL stop_busy got %b exp 0", busy);          else chk_ok++;
    chk_n++; if (level !== 5'd7)    $display("FAIL stop_level got %0d exp 7", level);       else chk_ok++;
    tick();
    chk_n++; if (data_vld !== 1'b0) $display("FAIL stop_vld_idle got %b exp 0", data_vld);  else chk_ok++;
    chk_n++; if (done_cnt !== 0)    $display("FAIL stop_no_done got %0d exp 0", done_cnt);  else chk_ok++;
    pkt_len = 16'd2;
    cfg_gap = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_n++; if (data_vld !== 1'b1 || data_i !== 16'd53) $display("FAIL stop_resume0 got vld=%b i=%0d exp vld=1 i=53", data_vld, data_i); else chk_ok++;
    tick();
    chk_n++; if (data_vld !== 1'b1 || data_i !== 16'd54) $display("FAIL stop_resume1 got vld=%b i=%0d exp vld=1 i=54", data_vld, data_i); else chk_ok++;
    chk_n++; if (done !== 1'b1) $display("FAIL stop_resume_done got %b exp 1", done); else chk_ok++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    push_n(70, 3);
    pkt_len = 16'd3;
    cfg_gap = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_n++; if (data_vld !== 1'b1 || data_i !== 16'd70) $display("FAIL ar_pre got vld=%b i=%0d exp vld=1 i=70", data_vld, data_i); else chk_ok++;
    #2;
    reset_n = 1'b0;
    #1;
    chk_n++; if (data_vld !== 1'b0) $display("FAIL ar_vld got %b exp 0", data_vld);     else chk_ok++;
    chk_n++; if (data_i !== 16'd0)  $display("FAIL ar_data_i got %0d exp 0", data_i);   else chk_ok++;
    chk_n++; if (data_q !== 16'd0)  $display("FAIL ar_data_q got %0d exp 0", data_q);   else chk_ok++;
    chk_n++; if (busy !== 1'b0)     $display("FAIL ar_busy got %b exp 0", busy);        else chk_ok++;
    chk_n++; if (level !== 5'd0)    $display("FAIL ar_level got %0d exp 0", level);     else chk_ok++;
    chk_n++; if (in_rdy !== 1'b1)   $display("FAIL ar_in_rdy got %b exp 1", in_rdy);    else chk_ok++;
    @(negedge clk);
    reset_n = 1'b1;
    pkt_len = 16'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk_n++; if (busy !== 1'b0) $display("FAIL ar_len0_busy got %b exp 0", busy); else chk_ok++;
    tick();
    chk_n++; if (busy !== 1'b0 || data_vld !== 1'b0) $display("FAIL ar_len0_idle got busy=%b vld=%b exp 0 0", busy, data_vld); else chk_ok++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", chk_n);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_underrun();
    test_full_wrap();
    test_stop();
    test_async_reset();
    $display("%0d/%0d checks passed", chk_ok, chk_n);
    $finish;
  end

endmodule
